// File: rtl/lvl_to_pulse_pkg.sv
// Shared defaults and helpers for the lvl_to_pulse key conditioner.
// Default timings assume a 50 MHz clk: 10 ms debounce, 0.5 s first repeat,
// then 0.1 s repeat period.
package lvl_to_pulse_pkg;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 25000000;
  localparam int DEF_REPEAT_PERIOD   = 5000000;

  // Bits needed to hold values 0..max_val, i.e. clog2(max_val+1), minimum 1.
  function automatic int cnt_width(input int max_val);
    int w;
    w = 1;
    while ((1 << w) <= max_val) w++;
    return w;
  endfunction

endpackage

// File: rtl/lvl_to_pulse_bit_sync.sv
// Single-bit multi-flop synchroniser with async active-low reset to RST_VAL.
module bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw level through the chain; reset loads the idle level.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ff <= {STAGES{RST_VAL}};
    else      ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/lvl_to_pulse.sv
// Push-button conditioner: synchronise, debounce and edge-detect one key
// level into a single-cycle pulse per press.
// Optional auto-repeat while held is enabled by defining
// LVL_TO_PULSE_AUTOREPEAT_EN; without it, one pulse per press only.
module lvl_to_pulse
  import lvl_to_pulse_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter bit ACTIVE_LOW      = 1'b1,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst,
  input  logic lvl_in,
  output logic pulse_out,
  output logic level_out
);

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  // Idle (released) raw level, so a key held through reset reads as a new press.
  localparam logic          SYNC_RST = ACTIVE_LOW;

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1)
  begin : g_param_check
    $error("lvl_to_pulse: illegal parameter value");
  end

  logic          sync_out;
  logic          p;
  logic          stable;
  logic          stable_d;
  logic          rise;
  logic          rpt_fire;
  logic [CW-1:0] db_cnt;

  bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (SYNC_RST)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (lvl_in),
    .q   (sync_out)
  );

  assign p    = ACTIVE_LOW ? ~sync_out : sync_out;
  assign rise = stable & ~stable_d;

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt <= '0;
      stable <= 1'b0;
    end else if (p == stable) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      stable <= p;
    end else begin
      db_cnt <= db_cnt + CW'(1);
    end
  end

`ifdef LVL_TO_PULSE_AUTOREPEAT_EN
  localparam int RW = cnt_width((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [RW-1:0] RPT_DELAY_LD  = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RPT_PERIOD_LD = RW'(REPEAT_PERIOD - 1);

  logic [RW-1:0] rpt_cnt;

  // Down-counter armed on the press pulse; terminal count fires and reloads.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 rpt_cnt <= '0;
    else if (!stable)         rpt_cnt <= '0;
    else if (rise)            rpt_cnt <= RPT_DELAY_LD;
    else if (rpt_cnt == '0)   rpt_cnt <= RPT_PERIOD_LD;
    else                      rpt_cnt <= rpt_cnt - RW'(1);
  end

  assign rpt_fire = stable & ~rise & (rpt_cnt == '0);
`else
  assign rpt_fire = 1'b0;
`endif

  // Registered edge detect on the debounced level, merged with repeat pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stable_d  <= 1'b0;
      pulse_out <= 1'b0;
    end else begin
      stable_d  <= stable;
      pulse_out <= rise | rpt_fire;
    end
  end

  assign level_out = stable;

endmodule

// File: tb/tb_lvl_to_pulse.sv
module tb_lvl_to_pulse;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam bit AL   = 1'b1;
  localparam int RD   = 10;
  localparam int RP   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic lvl_in = 1'b1;
  logic pulse_out;
  logic level_out;

  int n_pass  = 0;
  int n_total = 0;

  lvl_to_pulse #(
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DB),
    .ACTIVE_LOW      (AL),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lvl_in    (lvl_in),
    .pulse_out (pulse_out),
    .level_out (level_out)
  );

  always #5 clk = ~clk;

  // Reference model: a key level is accepted once the last DB synchronised
  // samples all disagree with the accepted level; press pulse follows one
  // cycle later; repeats are scheduled by elapsed hold time.
  bit m_samp [SYNC];
  bit m_pw   [DB];
  bit m_stable, m_stable_d, m_pulse;
  int m_since;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_samp[i] = 1'b0;
    for (int i = 0; i < DB; i++)   m_pw[i]   = 1'b0;
    m_stable   = 1'b0;
    m_stable_d = 1'b0;
    m_pulse    = 1'b0;
    m_since    = 0;
  endtask

  task automatic model_step();
    bit p, all_diff, r, f;
    int s;
    if (!rst) begin
      model_reset();
    end else begin
      p = m_samp[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_samp[i] = m_samp[i-1];
      m_samp[0] = AL ? ~lvl_in : lvl_in;
      for (int i = DB-1; i > 0; i--) m_pw[i] = m_pw[i-1];
      m_pw[0] = p;
      all_diff = 1'b1;
      for (int i = 0; i < DB; i++) if (m_pw[i] == m_stable) all_diff = 1'b0;
      r = m_stable & ~m_stable_d;
      f = 1'b0;
      s = m_since + 1;
`ifdef LVL_TO_PULSE_AUTOREPEAT_EN
      if (m_stable && !r) f = (s == RD) || (s > RD && ((s - RD) % RP) == 0);
`endif
      m_since    = r ? 0 : (m_stable ? s : 0);
      m_pulse    = r | f;
      m_stable_d = m_stable;
      if (all_diff) m_stable = ~m_stable;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    int np;
    rst = 1'b0; lvl_in = 1'b1;
    repeat (3) step();
    if (pulse_out !== 1'b0 || level_out !== 1'b0)
      $display("FAIL reset_state: pulse_out=%b level_out=%b required 0 0", pulse_out, level_out);
    else n_pass++;
    n_total++;
    rst = 1'b1;
    np = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      np += int'(pulse_out === 1'b1);
      if (pulse_out !== m_pulse || level_out !== m_stable)
        $display("FAIL reset_idle cyc=%0d: pulse_out=%b level_out=%b required %b %b", i, pulse_out, level_out, m_pulse, m_stable);
      else n_pass++;
      n_total++;
    end
    if (np != 0) $display("FAIL reset_no_pulse: pulses=%0d required 0", np);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_clean_press();
    int fp, fl, np;
    fp = -1; fl = -1; np = 0;
    lvl_in = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (pulse_out === 1'b1 && fp < 0) fp = i;
      if (level_out === 1'b1 && fl < 0) fl = i;
      np += int'(pulse_out === 1'b1);
      if (pulse_out !== m_pulse || level_out !== m_stable)
        $display("FAIL press cyc=%0d: pulse_out=%b level_out=%b required %b %b", i, pulse_out, level_out, m_pulse, m_stable);
      else n_pass++;
      n_total++;
    end
    if (fp != SYNC + DB + 1) $display("FAIL press_pulse_latency: got %0d required %0d", fp, SYNC + DB + 1);
    else n_pass++;
    n_total++;
    if (fl != SYNC + DB) $display("FAIL press_level_latency: got %0d required %0d", fl, SYNC + DB);
    else n_pass++;
    n_total++;
    if (np != 1) $display("FAIL press_pulse_count: got %0d required 1", np);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_release();
    int fl, np;
    fl = -1; np = 0;
    lvl_in = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (level_out === 1'b0 && fl < 0) fl = i;
      np += int'(pulse_out === 1'b1);
      if (pulse_out !== m_pulse || level_out !== m_stable)
        $display("FAIL release cyc=%0d: pulse_out=%b level_out=%b required %b %b", i, pulse_out, level_out, m_pulse, m_stable);
      else n_pass++;
      n_total++;
    end
    if (fl != SYNC + DB) $display("FAIL release_level_latency: got %0d required %0d", fl, SYNC + DB);
    else n_pass++;
    n_total++;
    if (np != 0) $display("FAIL release_no_pulse: pulses=%0d required 0", np);
    else n_pass++;
    n_total++;
  endtask

  task automatic test_bounce();
    int fp, np;
    fp = -1; np = 0;
    for (int i = 1; i <= 18; i++) begin
      lvl_in = (i == 4) ? 1'b1 : 1'b0;
      step();
      if (pulse_out === 1'b1 && fp < 0) fp = i;
      np += int'(pulse_out === 1'b1);
      if (pulse_out !== m_pulse || level_out !== m_stable)
        $display("FAIL bounce cyc=%0d: pulse_out=%b level_out=%b required %b %b", i, pulse_out, level_out, m_pulse, m_stable);
      else n_pass++;
      n_total++;
    end
    // final falling edge first sampled at cycle 5
    if (fp != 5 + SYNC + DB) $display("FAIL bounce_pulse_time: got %0d required %0d", fp, 5 + SYNC + DB);
    else n_pass++;
    n_total++;
    if (np != 1) $display("FAIL bounce_pulse_count: got %0d required 1", np);
    else n_pass++;
    n_total++;
    lvl_in = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_reset_mid();
    int fp, np;
    fp = -1; np = 0;
    lvl_in = 1'b0;
    repeat (2) begin
      step();
      np += int'(pulse_out === 1'b1);
    end
    rst = 1'b0;
    repeat (2) begin
      step();
      np += int'(pulse_out === 1'b1);
    end
    rst = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (pulse_out === 1'b1 && fp < 0) fp = i;
      np += int'(pulse_out === 1'b1);
      if (pulse_out !== m_pulse || level_out !== m_stable)
        $display("FAIL reset_mid cyc=%0d: pulse_out=%b level_out=%b required %b %b", i, pulse_out, level_out, m_pulse, m_stable);
      else n_pass++;
      n_total++;
    end
    if (fp != SYNC + DB + 1) $display("FAIL reset_mid_latency: got %0d required %0d", fp, SYNC + DB + 1);
    else n_pass++;
    n_total++;
    if (np != 1) $display("FAIL reset_mid_count: got %0d required 1", np);
    else n_pass++;
    n_total++;
    lvl_in = 1'b1;
    repeat (12) step();
  endtask

  task automatic test_hold();
    int np, exp_np;
    bit ep;
    localparam int P = SYNC + DB + 1;
    np = 0; exp_np = 0;
    lvl_in = 1'b0;
    for (int i = 1; i <= 32; i++) begin
      step();
      ep = (i == P);
`ifdef LVL_TO_PULSE_AUTOREPEAT_EN
      if (i >= P + RD && ((i - P - RD) % RP) == 0) ep = 1'b1;
`endif
      exp_np += int'(ep);
      np += int'(pulse_out === 1'b1);
      if (pulse_out !== ep || pulse_out !== m_pulse || level_out !== m_stable)
        $display("FAIL hold cyc=%0d: pulse_out=%b level_out=%b required %b %b", i, pulse_out, level_out, ep, m_stable);
      else n_pass++;
      n_total++;
    end
    if (np != exp_np) $display("FAIL hold_pulse_count: got %0d required %0d", np, exp_np);
    else n_pass++;
    n_total++;
    lvl_in = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      step();
      if (pulse_out !== m_pulse || level_out !== m_stable)
        $display("FAIL hold_release cyc=%0d: pulse_out=%b level_out=%b required %b %b", i, pulse_out, level_out, m_pulse, m_stable);
      else n_pass++;
      n_total++;
    end
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int i = 1; i <= 600; i++) begin
      if (run == 0) begin
        lvl_in = ~lvl_in;
        run = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 6);
      end
      run--;
      rst = ($urandom_range(0, 79) == 0) ? 1'b0 : 1'b1;
      step();
      if (pulse_out !== m_pulse || level_out !== m_stable)
        $display("FAIL random cyc=%0d: pulse_out=%b level_out=%b required %b %b", i, pulse_out, level_out, m_pulse, m_stable);
      else n_pass++;
      n_total++;
    end
    rst = 1'b1;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid();
    test_hold();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
